// File: rtl/mulsa_unit.sv
// mulsa_unit: sequential unsigned shift-add multiplier.
// It uses the same start/ready handshake as the restoring divider.
// The multiplier is scanned MSB-first, one bit per MUL cycle.
// Optional macro MULSA_EARLY_TERM_EN:
//   - Defined: a priority encoder starts the scan at the highest set bit
//     of B, so leading zero bits cost no cycles.
//   - Undefined: every operation runs exactly WIDTH MUL cycles.
//   The product is identical in both builds; only latency changes.
module mulsa_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] product,
  output logic               ready,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LOAD = 2'd2,
    MUL  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [CNT_W-1:0]     r_idx;
  logic [CNT_W-1:0]     w_start_idx;
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   w_addend;
  logic                 r_done;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: start is only looked at in IDLE and HOLD.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = HOLD;
      HOLD:    if (!start) w_next = LOAD;
      LOAD:    w_next = MUL;
      MUL:     if (r_idx == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef MULSA_EARLY_TERM_EN
  // Priority encoder: index of the highest set bit of B, or 0 when B is 0.
  always_comb begin
    w_start_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_b[i]) w_start_idx = CNT_W'(i);
    end
  end
`else
  assign w_start_idx = CNT_W'(WIDTH - 1);
`endif

  assign w_addend = r_b[r_idx] ? {{WIDTH{1'b0}}, r_a} : '0;

  // Datapath: capture operands in IDLE, clear in LOAD, and in MUL perform
  // one shift-add step per cycle, pulsing done on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a <= a_in;
            r_b <= b_in;
          end
        end
        LOAD: begin
          r_product <= '0;
          r_idx     <= w_start_idx;
        end
        MUL: begin
          r_product <= (r_product << 1) + w_addend;
          if (r_idx == '0) begin
            r_done <= 1'b1;
          end else begin
            r_idx <= r_idx - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
  assign done    = r_done;
  assign ready   = (r_state == IDLE);

endmodule

// File: tb/tb_mulsa_unit.sv
// tb_mulsa_unit: randomized self-checking bench for mulsa_unit (WIDTH=8).
// Expected products come from plain multiplication. Expected latency comes
// from the highest set bit of the multiplier, or from WIDTH when the
// MULSA_EARLY_TERM_EN build is not selected.
module tb_mulsa_unit;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [2*WIDTH-1:0] product;
  logic               ready;
  logic               done;

  int checks = 0;
  int errors = 0;

  mulsa_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .product (product),
    .ready   (ready),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: number of MUL iterations for a multiplier value.
  function automatic int expIters(input int b);
`ifdef MULSA_EARLY_TERM_EN
    int v;
    int m;
    v = b;
    m = 0;
    while (v > 1) begin
      v = v / 2;
      m++;
    end
    return m + 1;
`else
    return WIDTH;
`endif
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request. Start is held for 'hold' edges and then released.
  // If 'scramble' is set, the operands change to 7/7 right after capture.
  task automatic applyStimulus(input int a, input int b, input int hold, input bit scramble);
    a_in  = WIDTH'(a);
    b_in  = WIDTH'(b);
    start = 1'b1;
    repeat (hold) begin
      tick();
      if (scramble) begin
        a_in = 8'd7;
        b_in = 8'd7;
      end
    end
    start = 1'b0;
  endtask

  // Step past the release edge, then count edges until done is seen.
  // The result is -1 if done never arrives within the budget.
  task automatic waitDone(output int n);
    n = -1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) tick();
    checks++;
    if (product !== 16'd0 || ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: product=%0d ready=%b done=%b, required product=0 ready=1 done=0",
               product, ready, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    a_in  = 8'd13;
    b_in  = 8'd11;
    start = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_ready_low: ready=%b, required 0", ready);
    end
    tick();
    tick();
    start = 1'b0;
    waitDone(n);
    checks++;
    if (n !== 1 + expIters(11)) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d cycles, required %0d", n, 1 + expIters(11));
    end
    checks++;
    if (product !== 16'd143) begin
      errors++;
      $display("[TB] FAIL basic_product: got %0d, required 143", product);
    end
    tick();
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || product !== 16'd143) begin
      errors++;
      $display("[TB] FAIL basic_done_pulse: done=%b ready=%b product=%0d, required 0 1 143",
               done, ready, product);
    end
  endtask

  task automatic test_boundaries();
    int av[5] = '{255, 200, 0, 1, 77};
    int bv[5] = '{255, 0, 128, 1, 1};
    int n;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(av[i], bv[i], 1, 1'b0);
      waitDone(n);
      checks++;
      if (product !== 16'(av[i] * bv[i])) begin
        errors++;
        $display("[TB] FAIL boundary_product %0d*%0d: got %0d, required %0d",
                 av[i], bv[i], product, av[i] * bv[i]);
      end
      checks++;
      if (n !== 1 + expIters(bv[i])) begin
        errors++;
        $display("[TB] FAIL boundary_latency %0d*%0d: got %0d, required %0d",
                 av[i], bv[i], n, 1 + expIters(bv[i]));
      end
      tick();
    end
  endtask

  task automatic test_operand_change();
    int n;
    applyStimulus(9, 5, 2, 1'b1);
    waitDone(n);
    checks++;
    if (product !== 16'd45) begin
      errors++;
      $display("[TB] FAIL operand_change: got %0d, required 45", product);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    applyStimulus(9, 5, 1, 1'b0);
    waitDone(n);
    checks++;
    if (product !== 16'd45 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first: product=%0d done=%b, required 45 1", product, done);
    end
    a_in  = 8'd3;
    b_in  = 8'd3;
    start = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || ready !== 1'b0 || product !== 16'd45) begin
      errors++;
      $display("[TB] FAIL b2b_accept: done=%b ready=%b product=%0d, required 0 0 45",
               done, ready, product);
    end
    start = 1'b0;
    waitDone(n);
    checks++;
    if (product !== 16'd9 || n !== 1 + expIters(3)) begin
      errors++;
      $display("[TB] FAIL b2b_second: product=%0d cycles=%0d, required 9 %0d",
               product, n, 1 + expIters(3));
    end
    tick();
  endtask

  task automatic test_reset_abort();
    bit sawDone;
    applyStimulus(13, 200, 1, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || product !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_abort: ready=%b product=%0d done=%b, required 1 0 0",
               ready, product, done);
    end
    tick();
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0 || product !== 16'd0 || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_abort_quiet: done_seen=%b product=%0d ready=%b, required 0 0 1",
               sawDone, product, ready);
    end
  endtask

  task automatic test_random();
    int a;
    int b;
    int n;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255)) >> $urandom_range(0, 7);
      applyStimulus(a, b, int'($urandom_range(1, 3)), 1'b0);
      waitDone(n);
      checks++;
      if (product !== 16'(a * b)) begin
        errors++;
        $display("[TB] FAIL random_product %0d*%0d: got %0d, required %0d", a, b, product, a * b);
      end
      checks++;
      if (n !== 1 + expIters(b)) begin
        errors++;
        $display("[TB] FAIL random_latency %0d*%0d: got %0d, required %0d",
                 a, b, n, 1 + expIters(b));
      end
      repeat (int'($urandom_range(0, 2))) tick();
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_operand_change();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mulsa_unit.md
Name: mulsa_unit

Overview:
- Sequential unsigned shift-add multiplier: the multiply counterpart of the team's restoring divider.
- Uses the same start/ready handshake as the divider, so both share the same host-side sequencer.
- Scans the multiplier MSB-first. Iteration count is bounded by a priority encoder on the multiplier (early termination).
- Self-contained: datapath registers, priority encoder, iteration counter and control FSM in one module.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2
CNT_W, $clog2(WIDTH), width of iteration index register

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; level-held by host, operation begins after release
a_in  input  WIDTH  multiplicand
b_in  input  WIDTH  multiplier
product  output  2*WIDTH  result register; valid when done pulses, held until next LOAD
ready  output  1  high only in IDLE
done  output  1  one-cycle registered pulse on completion

Behaviour:
- Reset: state=IDLE, product=0, internal A/B/index=0, done=0, ready=1. Asserting rst mid-operation aborts immediately; no partial result retained.
- States: IDLE, HOLD, LOAD, MUL.
- IDLE: ready=1.
  - On an edge with start=1: capture a_in->A, b_in->B; go to HOLD.
  - a_in/b_in are sampled only on that edge.
- HOLD: ready=0.
  - Stay while start=1; go to LOAD on first edge with start=0.
  - No register updates; operand changes are ignored.
- LOAD (1 cycle): product<=0; idx<=msb(B); go to MUL.
  - msb(B) is the index of the highest set bit of B.
  - msb(0) is defined as 0.
- MUL (one iteration per cycle):
  - product <= (product<<1) + (B[idx] ? zero-extended A : 0), computed at 2*WIDTH bits; overflow is impossible.
  - If idx==0: go to IDLE and set done<=1 for exactly the next cycle. Otherwise idx<=idx-1.
- Iterations: msb(B)+1, in the range 1..WIDTH.
- Latency, measured from the edge where HOLD sees start=0: 1 (LOAD) + msb(B)+1 cycles until the IDLE return edge.
- done is high during the first IDLE cycle after MUL and low everywhere else.
- start is ignored in HOLD (beyond release), LOAD and MUL; a new request is accepted only in IDLE.
- Back-to-back: start=1 in the IDLE cycle where done=1 is accepted. done still clears on the next edge.
- Boundary cases:
  - B=0: 1 iteration, product=0.
  - A=0: full iteration count, product=0.
  - B=1: 1 iteration, product=A.
- product stays stable from completion until the next LOAD, including through HOLD.

Optional Feature:
- Macro: MULSA_EARLY_TERM_EN.
- Defined: LOAD sets idx=msb(B) via the priority encoder, as described above.
- Undefined:
  - No priority encoder; LOAD sets idx=WIDTH-1, so every operation runs exactly WIDTH MUL cycles.
  - Leading zero bits add nothing, so the product is bit-identical.
  - Only latency and done timing change.

Test Plan (WIDTH=8, early termination enabled unless stated):
- Reset -> product=0, ready=1, done=0. Reset asserted in MUL cycle 2 of 13*200 -> next cycle IDLE, product=0, no done pulse.
- a=13, b=11, start held 3 cycles then released -> ready low from the first start edge. LOAD, then 4 MUL cycles (msb=3). done pulses once; product=143.
- a=255, b=255 -> 8 MUL cycles; product=65025. a=200, b=0 -> 1 MUL cycle; product=0. a=0, b=128 -> 8 MUL cycles; product=0.
- a_in/b_in changed to 7/7 while HOLD and during MUL of 9*5 -> product=45, not 49.
- Back-to-back: 9*5 then start=1 in the done cycle with 3*3 -> product=45 with done, then product=9 with a second done; no lost request.
- MULSA_EARLY_TERM_EN undefined: 13*11 -> exactly 8 MUL cycles, product=143. Repeat the early-termination vectors and compare products equal.
